// File: rtl/multi_port_mem_arbiter_pkg.sv
// Shared state encoding, arbitration modes and counter sizing for the N-port memory arbiter.
package multi_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int GNT_CNT_W = 16;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_port_mem_arbiter_picker.sv
// Combinational picker: first requester after the pointer, wrapping; fixed mode pins the pointer
// to the last index so the lowest set request always wins.
module rr_priority_picker
  import multi_port_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ARB_MODE  = ARB_RR,
  parameter int IW        = idx_width(NUM_PORTS)
)(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IW-1:0]        i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IW-1:0]        o_idx,
  output logic                 o_any
);

  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_k;

  assign w_ptr = (ARB_MODE == ARB_FIXED) ? IW'(NUM_PORTS - 1) : i_ptr;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_k = IW'((int'(w_ptr) + i) % NUM_PORTS);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_arbiter.sv
// N-port arbiter onto one memory port, one transaction in flight; request->ISSUE 1 cycle, mem_valid->port_valid 1 cycle.
// Stalls in ISSUE while mem_ready is low; losing requesters stay pending on their own inputs.
module multi_port_mem_arbiter
  import multi_port_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int ARB_MODE       = ARB_RR,
  parameter int TIMEOUT_CYCLES = 1000
)(
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                port_read,
  input  logic [NUM_PORTS-1:0]                port_write,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   port_byte_en,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0]   port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_data_in,
  output logic [NUM_PORTS-1:0]                port_ready,
  output logic [NUM_PORTS-1:0]                port_valid,
  output logic                                port_error,
  output logic [DATA_WIDTH-1:0]               port_data_out,
  output logic [ADDRESS_BITS-1:0]             port_address_out,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [DATA_WIDTH/8-1:0]             mem_byte_en,
  output logic [ADDRESS_BITS-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]               mem_data_out,
  input  logic                                mem_ready,
  input  logic                                mem_valid,
  input  logic [DATA_WIDTH-1:0]               mem_data_in,
  input  logic [ADDRESS_BITS-1:0]             mem_address_in,
  output logic [NUM_PORTS*GNT_CNT_W-1:0]      grant_count
);

  localparam int IW  = idx_width(NUM_PORTS);
  localparam int BW  = DATA_WIDTH / 8;
  localparam int WCW = idx_width(TIMEOUT_CYCLES);
  // Last WAIT cycle before the timeout response is forced.
  localparam logic [WCW-1:0] TO_LAST = WCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t              r_state, w_state_nxt;
  logic [NUM_PORTS-1:0]    w_req, w_gnt_oh, r_gnt_oh;
  logic [IW-1:0]           w_gnt_idx, r_gnt, r_ptr;
  logic                    w_gnt_any, w_timeout;
  logic                    r_is_write;
  logic [ADDRESS_BITS-1:0] r_addr, r_rsp_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rsp_data;
  logic [BW-1:0]           r_be;
  logic                    r_rsp_err;
  logic [WCW-1:0]          r_wait_cnt;
  logic [GNT_CNT_W-1:0]    r_gcnt [NUM_PORTS];

  assign w_req     = port_read | port_write;
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_wait_cnt == TO_LAST);

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS), .ARB_MODE(ARB_MODE), .IW(IW)) u_picker (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_any) w_state_nxt = ISSUE;
      ISSUE:   if (mem_ready) w_state_nxt = WAIT;
      WAIT:    if (mem_valid || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gnt      <= '0;
      r_gnt_oh   <= '0;
      r_ptr      <= IW'(NUM_PORTS - 1);
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rsp_addr <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_wait_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_gcnt[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_any) begin
          r_gnt      <= w_gnt_idx;
          r_gnt_oh   <= w_gnt_oh;
          // A port raising both read and write is served as a write.
          r_is_write <= port_write[w_gnt_idx];
          r_addr     <= port_address[w_gnt_idx*ADDRESS_BITS +: ADDRESS_BITS];
          r_wdata    <= port_data_in[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          r_be       <= port_byte_en[w_gnt_idx*BW +: BW];
        end
        ISSUE: if (mem_ready) begin
          r_wait_cnt <= '0;
          if (ARB_MODE == ARB_RR) r_ptr <= r_gnt;
          if (r_gcnt[r_gnt] != '1) r_gcnt[r_gnt] <= r_gcnt[r_gnt] + 1'b1;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (mem_valid) begin
            r_rsp_data <= mem_data_in;
            r_rsp_addr <= mem_address_in;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_addr <= r_addr;
            r_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign port_ready       = {NUM_PORTS{r_state == IDLE}};
  assign port_valid       = (r_state == RESP) ? r_gnt_oh : '0;
  assign port_error       = (r_state == RESP) && r_rsp_err;
  assign port_data_out    = r_rsp_data;
  assign port_address_out = r_rsp_addr;
  assign mem_read         = (r_state == ISSUE) && !r_is_write;
  assign mem_write        = (r_state == ISSUE) && r_is_write;
  assign mem_byte_en      = r_be;
  assign mem_address      = r_addr;
  assign mem_data_out     = r_wdata;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt_out
    assign grant_count[gi*GNT_CNT_W +: GNT_CNT_W] = r_gcnt[gi];
  end

endmodule

// File: doc/multi_port_mem_arbiter.md
Name: multi_port_mem_arbiter

Overview:
- N-requester memory-port arbiter sitting between per-core memory_interface ports (I- and D-side, any core count) and one shared cache or main-memory request port.
- Generalises the fixed two-core, two-way wiring into a parametrised port count.
- Selects fixed-priority or round-robin arbitration.
- Keeps one outstanding transaction, routes the response back to the requester, and returns an error response on downstream timeout.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- DATA_WIDTH, 32, data bus width.
- ADDRESS_BITS, 32, address width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 1000, WAIT cycles before error response; 0 disables the timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- port_read  in  NUM_PORTS  per-port read request, level, held until that port's port_valid.
- port_write  in  NUM_PORTS  per-port write request, level.
- port_byte_en  in  NUM_PORTS*DATA_WIDTH/8  write byte enables.
- port_address  in  NUM_PORTS*ADDRESS_BITS  request address.
- port_data_in  in  NUM_PORTS*DATA_WIDTH  write data.
- port_ready  out  NUM_PORTS  arbiter accepting new requests.
- port_valid  out  NUM_PORTS  one-cycle response strobe.
- port_error  out  1  qualifies port_valid; 1 = timeout.
- port_data_out  out  DATA_WIDTH  response data, shared bus.
- port_address_out  out  ADDRESS_BITS  response address.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_byte_en  out  DATA_WIDTH/8  downstream byte enables.
- mem_address  out  ADDRESS_BITS  downstream address.
- mem_data_out  out  DATA_WIDTH  downstream write data.
- mem_ready  in  1  downstream can accept a request.
- mem_valid  in  1  downstream response valid (reads and writes).
- mem_data_in  in  DATA_WIDTH  downstream response data.
- mem_address_in  in  ADDRESS_BITS  downstream response address.
- grant_count  out  NUM_PORTS*16  per-port saturating grant counters.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; rr pointer = NUM_PORTS-1, so port 0 is first in line; port_ready all 1; all other outputs 0; grant_count 0.
- The reset action is the same when reset is asserted mid-transaction: the in-flight request is dropped and no port_valid is issued.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Request vector req[i] = port_read[i] | port_write[i].
  - If req is nonzero, pick winner g and register it. Fixed mode takes the lowest set index. RR mode takes the first set index after the pointer, wrapping modulo NUM_PORTS.
  - Latch g's address, data, byte_en and op.
  - Go to ISSUE next cycle. port_ready goes all 0 from that cycle.
- Read and write both high on one port: the write wins and the read is ignored for that transaction.
- ISSUE:
  - mem_read/mem_write (latched op) asserted with latched address, data and byte_en.
  - Held until a cycle with mem_ready=1, then go to WAIT and deassert next cycle.
  - In RR mode the pointer updates to g on that handshake.
  - grant_count[g] increments on that handshake and saturates at 0xFFFF.
- WAIT:
  - On mem_valid=1: capture mem_data_in and mem_address_in, go to RESP, port_error=0.
  - If TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES with no mem_valid: go to RESP with port_error=1 and port_data_out=0.
  - The wait counter clears on entry to WAIT.
- RESP:
  - port_valid[g]=1 for exactly one cycle, with port_data_out, port_address_out and port_error stable.
  - Next state IDLE; port_ready returns to all 1.
  - A request held by the same port is re-arbitrated no earlier than the IDLE cycle that follows.
- mem_valid outside WAIT is ignored.
- Minimum latency: request sampled in IDLE at edge 0, ISSUE at cycle 1, WAIT at cycle 2. mem_valid at cycle k gives port_valid at cycle k+1.
- Non-granted requests are not buffered. They stay pending on their inputs.
- RR guarantees a held request waits at most NUM_PORTS-1 grants.
- Counters, the pointer and the winner index are sized by clog2 of their range.

Decomposition:
- Package multi_port_arb_pkg holds:
  - state encodings IDLE/ISSUE/WAIT/RESP;
  - ARB_FIXED=0, ARB_RR=1;
  - grant counter width 16.
- One sub-module, rr_priority_picker (req vector plus pointer gives a one-hot grant and index; fixed mode forces pointer = NUM_PORTS-1).

Test Plan:
- Single read: port 2 reads 0x100, mem_ready=1, mem_valid with 0xDEADBEEF 3 cycles after WAIT entry -> port_valid=4'b0100 for 1 cycle, port_data_out=0xDEADBEEF, port_error=0, grant_count[2]=1.
- RR fairness: ports 0-3 all read continuously, zero-latency memory -> grant order 0,1,2,3,0; grant_count all 2 after 8 transactions.
- Fixed priority (ARB_MODE=0): ports 1 and 3 requesting -> port 1 granted every time, port 3 never, grant_count[3]=0.
- Backpressure: mem_ready low for 5 cycles in ISSUE -> mem_read held 6 cycles, address stable, no early WAIT.
- Timeout (TIMEOUT_CYCLES=8): write from port 0, no mem_valid -> port_valid[0] exactly 8 cycles after WAIT entry, port_error=1.
- Reset mid-WAIT: assert reset (0) -> all outputs at reset values immediately; a late mem_valid produces no port_valid.
